// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer.
// One-hot state encoding, BCD widths and parameter helpers.
package reaction_pkg;

   localparam int DIGIT_W = 4;
   localparam int BCD_W = 4 * DIGIT_W;
   localparam int TIMEOUT_MS_DEF = 9999;
   localparam int MIN_VALID_MS_DEF = 100;

   typedef enum logic [5:0] {
      S_IDLE        = 6'b000001,
      S_ARMED       = 6'b000010,
      S_TIMING      = 6'b000100,
      S_DONE        = 6'b001000,
      S_FALSE_START = 6'b010000,
      S_TIMED_OUT   = 6'b100000
   } state_e;

   // Binary constant (0..9999) to 4-digit BCD.
   function automatic logic [BCD_W-1:0] bin_to_bcd(input int v);
      logic [BCD_W-1:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

endpackage

// File: rtl/reaction_timer_fsm_if.sv
// Event inputs and result outputs of the reaction timer.
// master drives the events, slave is the timer.
interface reaction_timer_fsm_if;
   import reaction_pkg::*;

   logic             tick_ms;
   logic             arm;
   logic             lights_out;
   logic             button;
   logic [BCD_W-1:0] result_bcd;
   logic             result_valid;
   logic             jump_start;
   logic             timing;
   logic             timeout;

   modport master (
      output tick_ms, arm, lights_out, button,
      input  result_bcd, result_valid, jump_start, timing, timeout
   );

   modport slave (
      input  tick_ms, arm, lights_out, button,
      output result_bcd, result_valid, jump_start, timing, timeout
   );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear.
// Holds at max_i instead of incrementing past it.
module bcd_counter4
   import reaction_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [BCD_W-1:0] max_i,
   output logic [BCD_W-1:0] val_o,
   output logic [BCD_W-1:0] nxt_o
);

   logic [BCD_W-1:0] val_q;
   logic [BCD_W-1:0] val_d;
   logic [BCD_W-1:0] inc_val;
   logic             carry;

   // Ripple the +1 through the digits, wrapping 9 to 0.
   always_comb begin
      inc_val = val_q;
      carry   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (val_q[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
               inc_val[i*DIGIT_W +: DIGIT_W] = 4'd0;
            end else begin
               inc_val[i*DIGIT_W +: DIGIT_W] =
                  val_q[i*DIGIT_W +: DIGIT_W] + 4'd1;
               carry = 1'b0;
            end
         end
      end
   end

   // Saturate at max, then select clear / increment / hold.
   always_comb begin
      nxt_o = (val_q == max_i) ? val_q : inc_val;
      val_d = val_q;
      if (clr_i) begin
         val_d = '0;
      end else if (inc_i) begin
         val_d = nxt_o;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         val_q <= '0;
      end else begin
         val_q <= val_d;
      end
   end

   assign val_o = val_q;

endmodule

// File: rtl/reaction_timer_fsm.sv
// Reaction timer: lights-out to button press in ms, BCD.
// Flags jump starts and timeouts; all outputs registered.
module reaction_timer_fsm
   import reaction_pkg::*;
#(
   parameter int TIMEOUT_MS   = TIMEOUT_MS_DEF,
   parameter int MIN_VALID_MS = MIN_VALID_MS_DEF
) (
   input logic                 clk,
   input logic                 rst,
   reaction_timer_fsm_if.slave io
);

   localparam logic [BCD_W-1:0] TO_BCD  = bin_to_bcd(TIMEOUT_MS);
   localparam logic [BCD_W-1:0] MIN_BCD = bin_to_bcd(MIN_VALID_MS);

   state_e           state_q;
   state_e           state_d;
   logic             btn_q;
   logic             press;
   logic             clr;
   logic             inc;
   logic [BCD_W-1:0] cnt;
   logic [BCD_W-1:0] cnt_nxt;
   logic             valid_q;
   logic             valid_d;
   logic             jump_q;
   logic             jump_d;
   logic             timing_q;
   logic             timing_d;
   logic             tmo_q;
   logic             tmo_d;

   assign press = io.button & ~btn_q;

   bcd_counter4 u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .inc_i (inc),
      .max_i (TO_BCD),
      .val_o (cnt),
      .nxt_o (cnt_nxt)
   );

   // Next state and counter control; arm overrides every other event.
   always_comb begin
      state_d = state_q;
      clr     = 1'b0;
      inc     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (io.arm) begin
               state_d = S_ARMED;
               clr     = 1'b1;
            end
         end
         S_ARMED: begin
            if (io.arm) begin
               clr = 1'b1;
            end else if (press) begin
               state_d = S_FALSE_START;
            end else if (io.lights_out) begin
               state_d = S_TIMING;
               clr     = 1'b1;
            end
         end
         S_TIMING: begin
            if (io.arm) begin
               state_d = S_ARMED;
               clr     = 1'b1;
            end else if (press) begin
               state_d = S_DONE;
            end else if (io.tick_ms) begin
               inc = 1'b1;
               if (cnt_nxt == TO_BCD) begin
                  state_d = S_TIMED_OUT;
               end
            end
         end
         S_DONE, S_FALSE_START, S_TIMED_OUT: begin
            if (io.arm) begin
               state_d = S_ARMED;
               clr     = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            clr     = 1'b1;
         end
      endcase
   end

   // Flags follow the state being entered so they appear one cycle after the event.
   always_comb begin
      valid_d  = (state_d == S_DONE);
      jump_d   = (state_d == S_FALSE_START) |
                 ((state_d == S_DONE) & (cnt < MIN_BCD));
      timing_d = (state_d == S_TIMING);
      tmo_d    = (state_d == S_TIMED_OUT);
   end

   // State, button history and flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         btn_q    <= 1'b0;
         valid_q  <= 1'b0;
         jump_q   <= 1'b0;
         timing_q <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         btn_q    <= io.button;
         valid_q  <= valid_d;
         jump_q   <= jump_d;
         timing_q <= timing_d;
         tmo_q    <= tmo_d;
      end
   end

   assign io.result_bcd   = cnt;
   assign io.result_valid = valid_q;
   assign io.jump_start   = jump_q;
   assign io.timing       = timing_q;
   assign io.timeout      = tmo_q;

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Bench for reaction_timer_fsm: directed cases plus random soup,
// every cycle compared against a millisecond-level reference model.
module tb_reaction_timer_fsm;

   localparam int TMO = 9999;
   localparam int MINV = 100;

   localparam int M_IDLE = 0;
   localparam int M_ARMED = 1;
   localparam int M_TIMING = 2;
   localparam int M_DONE = 3;
   localparam int M_FS = 4;
   localparam int M_TO = 5;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   int   m_mode = M_IDLE;
   int   m_cnt = 0;
   bit   m_btn = 1'b0;

   always #5 clk = ~clk;

   reaction_timer_fsm_if io ();

   reaction_timer_fsm #(
      .TIMEOUT_MS   (TMO),
      .MIN_VALID_MS (MINV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] dec2bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10),
              4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [31:0] outs();
      return 32'({io.result_bcd, io.result_valid, io.jump_start,
                  io.timing, io.timeout});
   endfunction

   function automatic logic [31:0] model_outs();
      logic v, j, g, o;
      v = (m_mode == M_DONE);
      j = (m_mode == M_FS) || ((m_mode == M_DONE) && (m_cnt < MINV));
      g = (m_mode == M_TIMING);
      o = (m_mode == M_TO);
      return 32'({dec2bcd(m_cnt), v, j, g, o});
   endfunction

   // One clock with the given inputs; model advances, all outputs compared.
   task automatic cyc(input bit r, input bit t, input bit a,
                      input bit l, input bit b);
      bit press;
      rst           = r;
      io.tick_ms    = t;
      io.arm        = a;
      io.lights_out = l;
      io.button     = b;
      @(posedge clk);
      if (r) begin
         m_mode = M_IDLE;
         m_cnt  = 0;
         m_btn  = 1'b0;
      end else begin
         press = b && !m_btn;
         m_btn = b;
         if (a) begin
            m_mode = M_ARMED;
            m_cnt  = 0;
         end else begin
            case (m_mode)
               M_ARMED: begin
                  if (press) m_mode = M_FS;
                  else if (l) begin
                     m_mode = M_TIMING;
                     m_cnt  = 0;
                  end
               end
               M_TIMING: begin
                  if (press) m_mode = M_DONE;
                  else if (t) begin
                     m_cnt++;
                     if (m_cnt >= TMO) m_mode = M_TO;
                  end
               end
               default: ;
            endcase
         end
      end
      #1;
      chk("cycle", outs(), model_outs());
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
   endtask

   task automatic start_run();
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0);
   endtask

   initial begin
      bit rb;
      rst = 1'b1;
      io.tick_ms = 1'b0;
      io.arm = 1'b0;
      io.lights_out = 1'b0;
      io.button = 1'b0;

      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("reset", outs(), 32'h0);

      // 237 ms normal reaction
      start_run();
      chk("t1_timing", 32'(io.timing), 32'h1);
      ticks(237);
      cyc(0, 0, 0, 0, 1);
      chk("t1_res", outs(), 32'({16'h0237, 4'b1000}));
      cyc(0, 0, 0, 0, 0);

      // press before lights_out
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("t2_fs", outs(), 32'({16'h0000, 4'b0100}));
      cyc(0, 0, 0, 1, 0);
      chk("t2_hold", outs(), 32'({16'h0000, 4'b0100}));

      // 42 ms anticipation
      start_run();
      ticks(42);
      cyc(0, 0, 0, 0, 1);
      chk("t3_res", outs(), 32'({16'h0042, 4'b1100}));
      cyc(0, 0, 0, 0, 0);

      // timeout
      start_run();
      ticks(TMO - 1);
      chk("t4_pre", outs(), 32'({16'h9998, 4'b0010}));
      ticks(1);
      chk("t4_tmo", outs(), 32'({16'h9999, 4'b0001}));
      ticks(3);
      cyc(0, 0, 0, 0, 1);
      chk("t4_hold", outs(), 32'({16'h9999, 4'b0001}));
      cyc(0, 0, 0, 0, 0);

      // press coincident with tick
      start_run();
      ticks(99);
      cyc(0, 1, 0, 0, 1);
      chk("t5_drop", outs(), 32'({16'h0099, 4'b1100}));
      cyc(0, 0, 0, 0, 0);

      // digit carry 0999 -> 1000
      start_run();
      ticks(999);
      chk("t5_0999", 32'(io.result_bcd), 32'h0999);
      ticks(1);
      chk("t5_1000", outs(), 32'({16'h1000, 4'b0010}));

      // arm mid-timing restarts
      cyc(0, 1, 1, 0, 1);
      chk("rearm", outs(), 32'h0);
      cyc(0, 0, 0, 0, 0);

      // reset during timing
      start_run();
      ticks(150);
      chk("t6_0150", 32'(io.result_bcd), 32'h0150);
      cyc(1, 1, 0, 0, 1);
      chk("t6_rst", outs(), 32'h0);
      cyc(0, 0, 0, 0, 1);
      chk("t6_idle", outs(), 32'h0);
      cyc(0, 0, 0, 0, 0);
      start_run();
      ticks(7);
      cyc(0, 0, 0, 0, 1);
      chk("t6_after", outs(), 32'({16'h0007, 4'b1100}));

      // random soup
      rb = 1'b1;
      for (int i = 0; i < 8000; i++) begin
         bit r, t, a, l;
         r = ($urandom_range(0, 999) == 0);
         t = ($urandom_range(0, 3) != 0);
         a = ($urandom_range(0, 149) == 0);
         l = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 59) == 0) rb = ~rb;
         cyc(r, t, a, l, rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
